if_fetch: RTL and testbench

Instruction-fetch stage of the pipelined MIPS datapath. It owns the PC and drives the instruction-memory request. It fills the IF/ID pipeline register with `{PCP1, instr}` for the decode stage, and it takes the redirect target (`jpc` / `jpc_avail`) that decode sends back over the same IF/ID interface. The block supports a variable-latency instruction memory, holds a fetched word when decode stalls, and keeps MIPS delay-slot ordering when a redirect arrives while a fetch is still in flight.

---
 rtl/if_fetch.sv | 144 ++++++++++++++
 tb/tb_if_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// request, and fills the IF/ID register with {PCP1, instr}. A one-entry
// skid buffer holds a fetched word while decode stalls. A redirect that
// arrives before the delay-slot word has been fetched is parked until
// that word comes back.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | request outstanding (or about to be issued after reset)
// S_FULL   | skid buffer holds a word for IF/ID, no request issued
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        jpc_avail_i,
    input  logic [29:0] jpc_i,
    output logic        imem_req_o,
    output logic [29:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [61:0] id_data_o,
    output logic        id_valid_o
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [29:0] buf_pcp1_q, buf_pcp1_d;
    logic        redir_v_q, redir_v_d;
    logic [29:0] redir_pc_q, redir_pc_d;
    logic        req_q, req_d;
    logic [61:0] id_data_q, id_data_d;
    logic        id_valid_q, id_valid_d;

    logic [29:0] pc_inc;
    logic        in_fetch;
    logic        fetch_ack;
    logic        avail;
    logic [31:0] word;
    logic [29:0] word_pcp1;
    logic        redir_acc;

    // Next-state decode for the FSM, IF/ID register, skid buffer and PC.
    always_comb begin
        pc_inc    = pc_q + 30'd1;
        in_fetch  = (state_q == S_FETCH);
        // req_q gates the ack so a late ack straight after reset is ignored.
        fetch_ack = in_fetch && req_q && imem_ack_i;
        avail     = fetch_ack || (state_q == S_FULL);
        word      = in_fetch ? imem_rdata_i : buf_instr_q;
        word_pcp1 = in_fetch ? pc_inc : buf_pcp1_q;
        redir_acc = jpc_avail_i && !stall_i && !flush_i;

        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pcp1_d  = buf_pcp1_q;
        redir_v_d   = redir_v_q;
        redir_pc_d  = redir_pc_q;
        id_data_d   = id_data_q;
        id_valid_d  = id_valid_q;

        if (flush_i) begin
            id_valid_d = 1'b0;
            id_data_d  = '0;
            state_d    = S_FETCH;
        end else if (stall_i) begin
            if (fetch_ack) begin
                buf_instr_d = imem_rdata_i;
                buf_pcp1_d  = pc_inc;
                state_d     = S_FULL;
            end
        end else if (avail) begin
            id_data_d  = {word_pcp1, word};
            id_valid_d = 1'b1;
            state_d    = S_FETCH;
        end else begin
            id_data_d  = '0;
            id_valid_d = 1'b0;
        end

        // A word leaving FETCH advances the PC; a redirect accepted in the
        // same cycle means that word is the delay slot.
        if (fetch_ack) begin
            redir_v_d = 1'b0;
            if (redir_acc) begin
                pc_d = jpc_i;
            end else if (redir_v_q) begin
                pc_d = redir_pc_q;
            end else begin
                pc_d = pc_inc;
            end
        end else if (redir_acc) begin
            if (state_q == S_FULL) begin
                // Buffered word is the delay slot; PC already moved past it.
                pc_d = jpc_i;
            end else begin
                redir_v_d  = 1'b1;
                redir_pc_d = jpc_i;
            end
        end

        req_d = (state_d == S_FETCH);
    end

    // All state and registered outputs; reset holds the request low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC[31:2];
            buf_instr_q <= '0;
            buf_pcp1_q  <= '0;
            redir_v_q   <= 1'b0;
            redir_pc_q  <= '0;
            req_q       <= 1'b0;
            id_data_q   <= '0;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pcp1_q  <= buf_pcp1_d;
            redir_v_q   <= redir_v_d;
            redir_pc_q  <= redir_pc_d;
            req_q       <= req_d;
            id_data_q   <= id_data_d;
            id_valid_q  <= id_valid_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign id_data_o   = id_data_q;
    assign id_valid_o  = id_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a small variable-latency memory responder
// is driven from the stimulus sequence; outputs are checked at the
// falling edge.
module tb_if_fetch;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        flush_i;
    logic        jpc_avail_i;
    logic [29:0] jpc_i;
    logic        imem_req_o;
    logic [29:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [61:0] id_data_o;
    logic        id_valid_o;

    int n_assert = 0;
    int n_fail   = 0;
    int lat      = 1;
    int cnt      = 0;

    if_fetch dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .jpc_avail_i  (jpc_avail_i),
        .jpc_i        (jpc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .id_data_o    (id_data_o),
        .id_valid_o   (id_valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b01, a} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [29:0] pcp1, input logic [29:0] iaddr);
        chk({tag, "_valid"}, 64'(id_valid_o), 64'd1);
        chk({tag, "_data"}, 64'(id_data_o), 64'({pcp1, mem_word(iaddr)}));
    endtask

    task automatic chk_bub(input string tag);
        chk({tag, "_valid"}, 64'(id_valid_o), 64'd0);
        chk({tag, "_data"}, 64'(id_data_o), 64'd0);
    endtask

    task automatic chk_addr(input string tag, input logic [29:0] a);
        chk(tag, 64'(imem_addr_o), 64'(a));
    endtask

    // Memory responder: acks on the lat-th cycle of a request.
    task automatic mem_drive();
        if (imem_req_o) begin
            if (cnt >= lat - 1) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem_word(imem_addr_o);
                cnt          = 0;
            end else begin
                imem_ack_i   = 1'b0;
                imem_rdata_i = 32'hBAD0_BAD0;
                cnt++;
            end
        end else begin
            imem_ack_i   = 1'b0;
            imem_rdata_i = 32'hBAD0_BAD0;
            cnt          = 0;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni       = 1'b0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        jpc_avail_i  = 1'b0;
        jpc_i        = '0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;

        // Reset values
        repeat (2) @(negedge clk_i);
        chk("rst_req", 64'(imem_req_o), 64'd0);
        chk_bub("rst_id");
        chk_addr("rst_addr", 30'hC00);
        rst_ni = 1'b1;
        step();
        chk("first_req", 64'(imem_req_o), 64'd1);
        chk_addr("first_addr", 30'hC00);
        chk_bub("first_id");

        // Zero-wait streaming
        for (int i = 0; i < 3; i++) begin
            mem_drive();
            step();
            chk_addr("zw_addr", 30'hC01 + 30'(i));
            chk_id("zw_id", 30'hC01 + 30'(i), 30'hC00 + 30'(i));
        end

        // Three-cycle latency: two bubbles, address held until ack
        lat = 3;
        cnt = 0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 2; j++) begin
                mem_drive();
                step();
                chk_bub("l3_bub");
                chk_addr("l3_hold", 30'hC03 + 30'(k));
            end
            mem_drive();
            step();
            chk_id("l3_id", 30'hC04 + 30'(k), 30'hC03 + 30'(k));
            chk_addr("l3_addr", 30'hC04 + 30'(k));
        end

        // Stall for four cycles while an ack arrives
        lat = 1;
        cnt = 0;
        stall_i = 1'b1;
        mem_drive();
        step();
        chk("st_req", 64'(imem_req_o), 64'd0);
        chk_addr("st_addr", 30'hC06);
        chk_id("st_hold", 30'hC05, 30'hC04);
        for (int i = 0; i < 3; i++) begin
            mem_drive();
            step();
            chk("st_req_n", 64'(imem_req_o), 64'd0);
            chk_id("st_hold_n", 30'hC05, 30'hC04);
        end
        stall_i = 1'b0;
        mem_drive();
        step();
        chk_id("st_drain", 30'hC06, 30'hC05);
        chk("st_req_back", 64'(imem_req_o), 64'd1);
        chk_addr("st_next", 30'hC06);
        mem_drive();
        step();
        chk_id("st_after", 30'hC07, 30'hC06);
        chk_addr("st_after_addr", 30'hC07);

        // Flush together with stall while FULL
        stall_i = 1'b1;
        mem_drive();
        step();
        chk("fl_req", 64'(imem_req_o), 64'd0);
        chk_addr("fl_addr", 30'hC08);
        flush_i = 1'b1;
        mem_drive();
        step();
        chk_bub("fl_bub");
        chk("fl_req_back", 64'(imem_req_o), 64'd1);
        chk_addr("fl_same", 30'hC08);
        flush_i = 1'b0;
        stall_i = 1'b0;
        mem_drive();
        step();
        chk_id("fl_next", 30'hC09, 30'hC08);
        chk_addr("fl_next_addr", 30'hC09);

        // Reset in the middle of a request, late ack across release
        lat = 3;
        cnt = 0;
        mem_drive();
        step();
        chk("rm_req", 64'(imem_req_o), 64'd1);
        rst_ni       = 1'b0;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("rm_req_low", 64'(imem_req_o), 64'd0);
        chk_bub("rm_id");
        chk_addr("rm_addr", 30'hC00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        chk("rm_req_up", 64'(imem_req_o), 64'd1);
        chk_addr("rm_first", 30'hC00);
        chk_bub("rm_late_ack");

        // Branch at C00 -> 1000, redirect parked while C01 is outstanding
        lat = 2;
        cnt = 0;
        mem_drive();
        step();
        chk_bub("br_b0");
        chk_addr("br_a0", 30'hC00);
        mem_drive();
        step();
        chk_id("br_br", 30'hC01, 30'hC00);
        chk_addr("br_a1", 30'hC01);
        jpc_avail_i = 1'b1;
        jpc_i       = 30'h0000_1000;
        mem_drive();
        step();
        jpc_avail_i = 1'b0;
        chk_bub("br_b1");
        chk_addr("br_hold", 30'hC01);
        mem_drive();
        step();
        chk_id("br_slot", 30'hC02, 30'hC01);
        chk_addr("br_tgt", 30'h0000_1000);
        mem_drive();
        step();
        chk_bub("br_b2");
        mem_drive();
        step();
        chk_id("br_tgt_id", 30'h0000_1001, 30'h0000_1000);
        chk_addr("br_cleared", 30'h0000_1001);

        // Redirect coinciding with a zero-wait fetch, then PC wrap
        lat = 1;
        cnt = 0;
        jpc_avail_i = 1'b1;
        jpc_i       = 30'h3FFF_FFFF;
        mem_drive();
        step();
        jpc_avail_i = 1'b0;
        chk_id("wr_slot", 30'h0000_1002, 30'h0000_1001);
        chk_addr("wr_tgt", 30'h3FFF_FFFF);
        mem_drive();
        step();
        chk_id("wr_id", 30'h0, 30'h3FFF_FFFF);
        chk_addr("wr_addr", 30'h0);

        // Redirect accepted while FULL replaces the advanced PC
        stall_i = 1'b1;
        mem_drive();
        step();
        chk("fr_req", 64'(imem_req_o), 64'd0);
        chk_addr("fr_adv", 30'h1);
        stall_i     = 1'b0;
        jpc_avail_i = 1'b1;
        jpc_i       = 30'h0000_2000;
        mem_drive();
        step();
        jpc_avail_i = 1'b0;
        chk_id("fr_slot", 30'h1, 30'h0);
        chk("fr_req_up", 64'(imem_req_o), 64'd1);
        chk_addr("fr_tgt", 30'h0000_2000);

        // Flush beats a simultaneous redirect
        flush_i      = 1'b1;
        jpc_avail_i  = 1'b1;
        jpc_i        = 30'h0000_3000;
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'hBAD0_BAD0;
        step();
        flush_i     = 1'b0;
        jpc_avail_i = 1'b0;
        chk_bub("fj_bub");
        chk_addr("fj_addr", 30'h0000_2000);
        mem_drive();
        step();
        chk_id("fj_id", 30'h0000_2001, 30'h0000_2000);
        chk_addr("fj_no_redir", 30'h0000_2001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
